mem_access_ctrl: RTL

- Initiator-side sequencer for the MAR/MDR/RAM memory subsystem.
- Accepts a single load or store request from the CPU control path.
- Drives the subsystem strobes (MARin, MDRin, read, write) and the shared bus in the correct phase order.
- Returns read data with a one-cycle done pulse; rejects out-of-range addresses without touching memory.

---
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the MAR/MDR/RAM memory subsystem: runs one load or
// store through the MAR/MDR strobe phases and reports completion or a range error.
module mem_access_ctrl #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata_out,
  output logic [31:0] bus_out,
  output logic        bus_drive,
  output logic        MARin,
  output logic        MDRin,
  output logic        read,
  output logic        write,
  input  logic [31:0] mem_data_in
);

  localparam int unsigned MaxLat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [2:0] {
    StIdle, StErr, StLoadMar, StLoadMdr, StWriteMem, StReadMem, StCapture, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [31:0]       addr_hi;
  logic              out_of_range;

  // Any bit above the physical address width makes the request illegal.
  assign addr_hi      = addr_in >> ADDR_BITS;
  assign out_of_range = |addr_hi;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && start) begin
        op_q    <= op_write;
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
      if (state_q == StCapture) begin
        rdata_q <= mem_data_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = out_of_range ? StErr : StLoadMar;
      end
      StErr:  state_d = StIdle;
      StLoadMar: begin
        if (op_q) begin
          state_d = StLoadMdr;
        end else begin
          state_d = StReadMem;
          cnt_d   = CntW'(READ_LAT - 1);
        end
      end
      StLoadMdr: begin
        state_d = StWriteMem;
        cnt_d   = CntW'(WRITE_LAT - 1);
      end
      StWriteMem: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StReadMem: begin
        if (cnt_q == '0) state_d = StCapture;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decode only the state register, so reset clears them asynchronously.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone) || (state_q == StErr);
    error     = (state_q == StErr);
    bus_drive = (state_q == StLoadMar) || (state_q == StLoadMdr);
    MARin     = (state_q == StLoadMar);
    MDRin     = (state_q == StLoadMdr) || (state_q == StReadMem);
    read      = (state_q == StReadMem);
    write     = (state_q == StWriteMem);
    bus_out   = 32'h0;
    if (state_q == StLoadMar) bus_out = addr_q;
    if (state_q == StLoadMdr) bus_out = wdata_q;
  end

  assign rdata_out = rdata_q;

endmodule
